// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Resolves rs1/rs2 forwarding (EX/MEM over MEM/WB, never x0), runs the ALU,
// evaluates conditional branches and jal, and owns the EX/MEM register.
// Ports:
//   clk, reset                clock (rising edge), async active-high reset
//   id_ex_*                   decoded instruction and operands from ID/EX
//   mem_wb_regwrite/rd/wdata  MEM/WB writeback info used for forwarding
//   branch_taken/target       combinational redirect request to fetch
//   ex_mem_*                  registered results and control for MEM
module ex_stage #(
  parameter int XLEN       = 64,
  parameter bit FWD_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_ex_branch,
  input  logic            id_ex_memread,
  input  logic            id_ex_memwrite,
  input  logic            id_ex_memtoreg,
  input  logic            id_ex_regwrite,
  input  logic            id_ex_alusrc,
  input  logic            id_ex_jal,
  input  logic [1:0]      id_ex_aluop,
  input  logic [3:0]      id_ex_funct,
  input  logic [4:0]      id_ex_rs1,
  input  logic [4:0]      id_ex_rs2,
  input  logic [4:0]      id_ex_rd,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_rdata1,
  input  logic [XLEN-1:0] id_ex_rdata2,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [XLEN-1:0] id_ex_pc_plus4,
  input  logic            mem_wb_regwrite,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_wdata,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_memtoreg,
  output logic            ex_mem_regwrite,
  output logic [4:0]      ex_mem_rd,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_wdata
);

  logic            memread_q, memwrite_q, memtoreg_q, regwrite_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, wdata_q;
  logic [XLEN-1:0] alu_result_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_out;
  logic            cond;

  // EX/MEM match wins over MEM/WB; x0 is a hardwired zero so it never forwards.
  // ex_mem memread is deliberately ignored: load-use stalls happen upstream.
  always_comb begin
    fwd_a = id_ex_rdata1;
    if (FWD_ENABLE && regwrite_q && rd_q != 5'd0 && rd_q == id_ex_rs1)
      fwd_a = alu_result_q;
    else if (FWD_ENABLE && mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1)
      fwd_a = mem_wb_wdata;
  end

  always_comb begin
    fwd_b = id_ex_rdata2;
    if (FWD_ENABLE && regwrite_q && rd_q != 5'd0 && rd_q == id_ex_rs2)
      fwd_b = alu_result_q;
    else if (FWD_ENABLE && mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2)
      fwd_b = mem_wb_wdata;
  end

  assign op_b = id_ex_alusrc ? id_ex_imm : fwd_b;

  always_comb begin
    alu_out = '0;
    case (id_ex_aluop)
      2'b00: alu_out = fwd_a + op_b;
      2'b01: alu_out = fwd_a - op_b;
      2'b10: begin
        case (id_ex_funct)
          4'b0000: alu_out = fwd_a + op_b;
          4'b1000: alu_out = fwd_a - op_b;
          4'b0111: alu_out = fwd_a & op_b;
          4'b0110: alu_out = fwd_a | op_b;
          4'b0100: alu_out = fwd_a ^ op_b;
          4'b0001: alu_out = fwd_a << op_b[5:0];
          4'b0101: alu_out = fwd_a >> op_b[5:0];
          4'b1101: alu_out = $signed(fwd_a) >>> op_b[5:0];
          4'b0010: alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
          default: alu_out = '0;
        endcase
      end
      default: alu_out = '0;
    endcase
  end

  // Branch compare always uses the register operands, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (id_ex_funct[2:0])
      3'b000:  cond = (fwd_a == fwd_b);
      3'b001:  cond = (fwd_a != fwd_b);
      3'b100:  cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken  = ~reset & ((id_ex_branch & cond) | id_ex_jal);
  assign branch_target = id_ex_pc + (id_ex_imm << 1);

  assign alu_result_d = id_ex_jal ? id_ex_pc_plus4 : alu_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      wdata_q      <= '0;
    end else begin
      memread_q    <= id_ex_memread;
      memwrite_q   <= id_ex_memwrite;
      memtoreg_q   <= id_ex_memtoreg;
      regwrite_q   <= id_ex_regwrite;
      rd_q         <= id_ex_rd;
      alu_result_q <= alu_result_d;
      wdata_q      <= fwd_b;
    end
  end

  assign ex_mem_memread    = memread_q;
  assign ex_mem_memwrite   = memwrite_q;
  assign ex_mem_memtoreg   = memtoreg_q;
  assign ex_mem_regwrite   = regwrite_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_alu_result = alu_result_q;
  assign ex_mem_wdata      = wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expectations are queued when an instruction is
// driven and compared after the edge that registers it into EX/MEM.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch, memread, memwrite, memtoreg, regwrite, alusrc, jal;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [63:0] pc, rdata1, rdata2, imm, pc_plus4, wb_wdata;
  logic        wb_regwrite;

  logic        bt, bt0;
  logic [63:0] tgt, tgt0;
  logic        o_mr, o_mw, o_mt, o_rw, o0_mr, o0_mw, o0_mt, o0_rw;
  logic [4:0]  o_rd, o0_rd;
  logic [63:0] o_alu, o_wd, o0_alu, o0_wd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp0_q[$];

  always #5 clk = ~clk;

  ex_stage #(.XLEN(64), .FWD_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .id_ex_branch(branch), .id_ex_memread(memread), .id_ex_memwrite(memwrite),
    .id_ex_memtoreg(memtoreg), .id_ex_regwrite(regwrite), .id_ex_alusrc(alusrc),
    .id_ex_jal(jal), .id_ex_aluop(aluop), .id_ex_funct(funct),
    .id_ex_rs1(rs1), .id_ex_rs2(rs2), .id_ex_rd(rd), .id_ex_pc(pc),
    .id_ex_rdata1(rdata1), .id_ex_rdata2(rdata2), .id_ex_imm(imm),
    .id_ex_pc_plus4(pc_plus4), .mem_wb_regwrite(wb_regwrite), .mem_wb_rd(wb_rd),
    .mem_wb_wdata(wb_wdata), .branch_taken(bt), .branch_target(tgt),
    .ex_mem_memread(o_mr), .ex_mem_memwrite(o_mw), .ex_mem_memtoreg(o_mt),
    .ex_mem_regwrite(o_rw), .ex_mem_rd(o_rd), .ex_mem_alu_result(o_alu),
    .ex_mem_wdata(o_wd)
  );

  ex_stage #(.XLEN(64), .FWD_ENABLE(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .id_ex_branch(branch), .id_ex_memread(memread), .id_ex_memwrite(memwrite),
    .id_ex_memtoreg(memtoreg), .id_ex_regwrite(regwrite), .id_ex_alusrc(alusrc),
    .id_ex_jal(jal), .id_ex_aluop(aluop), .id_ex_funct(funct),
    .id_ex_rs1(rs1), .id_ex_rs2(rs2), .id_ex_rd(rd), .id_ex_pc(pc),
    .id_ex_rdata1(rdata1), .id_ex_rdata2(rdata2), .id_ex_imm(imm),
    .id_ex_pc_plus4(pc_plus4), .mem_wb_regwrite(wb_regwrite), .mem_wb_rd(wb_rd),
    .mem_wb_wdata(wb_wdata), .branch_taken(bt0), .branch_target(tgt0),
    .ex_mem_memread(o0_mr), .ex_mem_memwrite(o0_mw), .ex_mem_memtoreg(o0_mt),
    .ex_mem_regwrite(o0_rw), .ex_mem_rd(o0_rd), .ex_mem_alu_result(o0_alu),
    .ex_mem_wdata(o0_wd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [1:0] a_op, input logic [3:0] f,
                    input logic [63:0] a, input logic [63:0] b);
    aluop = a_op; funct = f; rdata1 = a; rdata2 = b;
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd10; alusrc = 1'b0; imm = '0;
    regwrite = 1'b1; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    branch = 1'b0; jal = 1'b0; pc = 64'h1000; pc_plus4 = 64'h1004;
  endtask

  task automatic expect_res(input logic [63:0] alu, input logic [63:0] wd);
    exp_t e;
    e.alu = alu; e.wdata = wd; e.rd = rd;
    e.ctl = {memread, memwrite, memtoreg, regwrite};
    exp_q.push_back(e);
  endtask

  task automatic expect_nofwd(input logic [63:0] alu, input logic [63:0] wd);
    exp_t e;
    e.alu = alu; e.wdata = wd; e.rd = rd;
    e.ctl = {memread, memwrite, memtoreg, regwrite};
    exp0_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".alu"},   o_alu, e.alu);
      chk({tag, ".wdata"}, o_wd,  e.wdata);
      chk({tag, ".rd"},    {59'd0, o_rd}, {59'd0, e.rd});
      chk({tag, ".ctl"},   {60'd0, o_mr, o_mw, o_mt, o_rw}, {60'd0, e.ctl});
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      chk({tag, ".nofwd_alu"},   o0_alu, e.alu);
      chk({tag, ".nofwd_wdata"}, o0_wd,  e.wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_regwrite = 1'b0; wb_rd = '0; wb_wdata = '0;
    reset = 1'b1;
    op(2'b10, 4'b0000, 64'h11, 64'h22);
    branch = 1'b1; jal = 1'b1; memread = 1'b1; memwrite = 1'b1; memtoreg = 1'b1;
    imm = 64'h40; rd = 5'd7;
    #12;
    chk("reset.alu", o_alu, 64'd0);
    chk("reset.wdata", o_wd, 64'd0);
    chk("reset.ctl_rd", {55'd0, o_mr, o_mw, o_mt, o_rw, o_rd}, 64'd0);
    chk("reset.taken", {63'd0, bt}, 64'd0);
    reset = 1'b0;

    // x5 = 4 + 6
    op(2'b00, 4'b0000, 64'd4, 64'd6); rd = 5'd5;
    expect_res(64'd10, 64'd6); expect_nofwd(64'd10, 64'd6);
    tick("add_x5");

    // add x6,x5,x5 with MEM/WB also holding x5=7: EX/MEM must win
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_wdata = 64'd7;
    op(2'b00, 4'b0000, 64'd1, 64'd1); rs1 = 5'd5; rs2 = 5'd5; rd = 5'd6;
    memtoreg = 1'b1;
    expect_res(64'd20, 64'd10); expect_nofwd(64'd2, 64'd1);
    tick("fwd_prio");

    wb_rd = 5'd3; wb_wdata = 64'h55;
    op(2'b00, 4'b0000, 64'd0, 64'h10); rs1 = 5'd3;
    expect_res(64'h65, 64'h10);
    tick("fwd_memwb");

    wb_rd = 5'd0;
    op(2'b00, 4'b0000, 64'h30, 64'h10); rs1 = 5'd0;
    expect_res(64'h40, 64'h10);
    tick("x0_guard");
    wb_regwrite = 1'b0;

    op(2'b00, 4'b0000, 64'd1, 64'hAB); alusrc = 1'b1; imm = 64'h100;
    regwrite = 1'b0; memwrite = 1'b1; memread = 1'b1; rd = 5'd7;
    expect_res(64'h101, 64'hAB);
    tick("store_imm");

    op(2'b01, 4'b0000, 64'd5, 64'd7);
    expect_res(64'hFFFF_FFFF_FFFF_FFFE, 64'd7);
    tick("aluop01");

    op(2'b01, 4'b0000, 64'd4, 64'd4); branch = 1'b1; regwrite = 1'b0;
    pc = 64'h100; imm = 64'd8;
    #1;
    chk("beq_eq.taken", {63'd0, bt}, 64'd1);
    chk("beq_eq.target", tgt, 64'h110);
    expect_res(64'd0, 64'd4);
    tick("beq_eq");

    op(2'b01, 4'b0000, 64'd4, 64'd5); branch = 1'b1; regwrite = 1'b0;
    #1; chk("beq_ne.taken", {63'd0, bt}, 64'd0);
    funct = 4'b0001;
    #1; chk("bne.taken", {63'd0, bt}, 64'd1);
    rdata1 = 64'hFFFF_FFFF_FFFF_FFFF; rdata2 = 64'd1; funct = 4'b0100;
    #1; chk("blt.taken", {63'd0, bt}, 64'd1);
    funct = 4'b0101;
    #1; chk("bge.taken", {63'd0, bt}, 64'd0);
    rdata1 = 64'd1;
    #1; chk("bge_eq.taken", {63'd0, bt}, 64'd1);
    funct = 4'b0010;
    #1; chk("bcode_other.taken", {63'd0, bt}, 64'd0);
    branch = 1'b0; funct = 4'b0000; rdata2 = 64'd1;
    #1; chk("nobranch.taken", {63'd0, bt}, 64'd0);
    expect_res(64'd0, 64'd1);
    tick("branch_misc");

    op(2'b00, 4'b0000, 64'd1, 64'd2); jal = 1'b1; rd = 5'd9;
    pc = 64'h200; pc_plus4 = 64'h204; imm = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("jal.taken", {63'd0, bt}, 64'd1);
    chk("jal.target", tgt, 64'h1F8);
    expect_res(64'h204, 64'd2);
    tick("jal");

    op(2'b10, 4'b0000, 64'h0F0F, 64'h00FF); expect_res(64'h100E, 64'h00FF); tick("add");
    op(2'b10, 4'b1000, 64'h0F0F, 64'h00FF); expect_res(64'h0E10, 64'h00FF); tick("sub");
    op(2'b10, 4'b0111, 64'h0F0F, 64'h00FF); expect_res(64'h000F, 64'h00FF); tick("and");
    op(2'b10, 4'b0110, 64'h0F0F, 64'h00FF); expect_res(64'h0FFF, 64'h00FF); tick("or");
    op(2'b10, 4'b0100, 64'h0F0F, 64'h00FF); expect_res(64'h0FF0, 64'h00FF); tick("xor");
    op(2'b10, 4'b0001, 64'd1, 64'h43); expect_res(64'd8, 64'h43); tick("sll");
    op(2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd63); expect_res(64'd1, 64'd63); tick("srl");
    op(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4);
    expect_res(64'hF800_0000_0000_0000, 64'd4); tick("sra");
    op(2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); expect_res(64'd1, 64'd1); tick("slt_lt");
    op(2'b10, 4'b0010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_res(64'd0, 64'hFFFF_FFFF_FFFF_FFFF); tick("slt_ge");
    op(2'b10, 4'b0011, 64'd5, 64'd3); expect_res(64'd0, 64'd3); tick("funct_bad");
    op(2'b11, 4'b0000, 64'd5, 64'd3); expect_res(64'd0, 64'd3); tick("aluop11");
    op(2'b00, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); expect_res(64'd1, 64'd2); tick("add_wrap");

    // reset in the middle of traffic clears EX/MEM without an edge
    op(2'b00, 4'b0000, 64'd3, 64'd4); jal = 1'b1;
    reset = 1'b1;
    #1;
    chk("midreset.alu", o_alu, 64'd0);
    chk("midreset.ctl_rd", {55'd0, o_mr, o_mw, o_mt, o_rw, o_rd}, 64'd0);
    chk("midreset.taken", {63'd0, bt}, 64'd0);
    reset = 1'b0;
    jal = 1'b0;
    expect_res(64'd7, 64'd4);
    tick("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
